// File: rtl/lsu_unit.sv
// lsu_unit: load/store responder driving a 32-bit word memory port with a req/ack handshake,
// lane steering for stores, sign/zero extension for loads, misalign/illegal/timeout errors.
module lsu_unit #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        MEM_WRITE_ENB,
  input  logic [2:0]  LSU_OPT,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] LSU_RESULT,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_WSTRB,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK
);
  typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic        req_q, req_d, we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
  logic [3:0]  strb_q, strb_d;
  logic [1:0]  size;
  logic        op_ok, misalign;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ext;
  // size: 0 byte, 1 halfword, 2 word; store encodings sit one above the load ones
  always_comb begin
    size     = MEM_WRITE_ENB ? LSU_OPT[1:0] - 2'd1 : LSU_OPT[1:0];
    op_ok    = MEM_WRITE_ENB ? (LSU_OPT[2] && LSU_OPT[1:0] != 2'b00)
                             : (LSU_OPT[1:0] != 2'b11 && LSU_OPT != 3'b110);
    misalign = (size == 2'd1 && ADDR[0]) || (size == 2'd2 && ADDR[1:0] != 2'b00);
    bsel     = 8'(MEM_RDATA >> {lane_q, 3'b000});
    hsel     = lane_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    ext      = op_q[1:0] == 2'b10 ? MEM_RDATA
             : op_q[1:0] == 2'b01 ? {{16{~op_q[2] & hsel[15]}}, hsel}
             : {{24{~op_q[2] & bsel[7]}}, bsel};
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    lane_d   = lane_q;
    req_d    = req_q;
    we_d     = we_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (REQ) begin
          if (!op_ok || misalign) begin
            err_d = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = 8'd0;
            op_d    = LSU_OPT;
            lane_d  = ADDR[1:0];
            req_d   = 1'b1;
            we_d    = MEM_WRITE_ENB;
            busy_d  = 1'b1;
            addr_d  = {ADDR[31:2], 2'b00};
            strb_d  = !MEM_WRITE_ENB ? 4'b0000
                    : size == 2'd0 ? 4'(4'b0001 << ADDR[1:0])
                    : size == 2'd1 ? (ADDR[1] ? 4'b1100 : 4'b0011)
                    : 4'b1111;
            wdata_d = !MEM_WRITE_ENB ? 32'd0
                    : size == 2'd0 ? {4{WDATA[7:0]}}
                    : size == 2'd1 ? {2{WDATA[15:0]}}
                    : WDATA;
          end
        end
      end
      ACCESS: begin
        if (MEM_ACK) begin
          state_d  = FINISH;
          req_d    = 1'b0;
          we_d     = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cnt_d    = 8'd0;
          result_d = we_q ? result_q : ext;
        end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      lane_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      lane_q   <= lane_d;
      req_q    <= req_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      result_q <= result_d;
    end
  end
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign LSU_RESULT = result_q;
  assign MEM_REQ    = req_q;
  assign MEM_WE     = we_q;
  assign MEM_ADDR   = addr_q;
  assign MEM_WSTRB  = strb_q;
  assign MEM_WDATA  = wdata_q;
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed vector table for lsu_unit plus hand sequences for timeout and reset corners.
module tb_lsu_unit;
  logic        clk = 1'b0;
  logic        rst, req, we, mem_ack;
  logic [2:0]  opt;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] result, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  int total = 0;
  int bad = 0;
  lsu_unit #(.ACK_TIMEOUT(4)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .MEM_WRITE_ENB(we), .LSU_OPT(opt),
    .ADDR(addr), .WDATA(wdata), .BUSY(busy), .DONE(done), .ERR(err),
    .LSU_RESULT(result), .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
    .MEM_WSTRB(mem_wstrb), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  typedef struct {
    logic        we;
    logic [2:0]  opt;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    logic [31:0] maddr;
    logic [3:0]  strb;
    logic [31:0] mwdata, res;
  } vec_t;
  vec_t v[18];
  logic [31:0] last_res;
  int n_done;
  initial begin
    v[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF};
    v[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFFFF80};
    v[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1'b0, 32'h100, 4'b0000, 32'h0, 32'h00000080};
    v[3]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h80123456, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFF8012};
    v[4]  = '{1'b0, 3'b101, 32'h102, 32'h0, 32'h80123456, 1'b0, 32'h100, 4'b0000, 32'h0, 32'h00008012};
    v[5]  = '{1'b0, 3'b001, 32'h100, 32'h0, 32'h12347FFF, 1'b0, 32'h100, 4'b0000, 32'h0, 32'h00007FFF};
    v[6]  = '{1'b0, 3'b000, 32'h101, 32'h0, 32'h0000C300, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFFFFC3};
    v[7]  = '{1'b1, 3'b101, 32'h202, 32'hA5, 32'h0, 1'b0, 32'h200, 4'b0100, 32'hA5A5A5A5, 32'h0};
    v[8]  = '{1'b1, 3'b110, 32'h202, 32'h1234, 32'h0, 1'b0, 32'h200, 4'b1100, 32'h12341234, 32'h0};
    v[9]  = '{1'b1, 3'b111, 32'h204, 32'hCAFEF00D, 32'h0, 1'b0, 32'h204, 4'b1111, 32'hCAFEF00D, 32'h0};
    v[10] = '{1'b1, 3'b110, 32'h200, 32'hFFFF5678, 32'h0, 1'b0, 32'h200, 4'b0011, 32'h56785678, 32'h0};
    v[11] = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
    v[12] = '{1'b1, 3'b110, 32'h203, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
    v[13] = '{1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
    v[14] = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
    v[15] = '{1'b1, 3'b001, 32'h100, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
    v[16] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h01020304, 1'b0, 32'hFFFFFFFC, 4'b0000, 32'h0, 32'h01020304};
    v[17] = '{1'b1, 3'b101, 32'h203, 32'h11223344, 32'h0, 1'b0, 32'h200, 4'b1000, 32'h44444444, 32'h0};
    rst = 1'b1; req = 1'b0; we = 1'b0; opt = 3'b0; addr = 32'h0; wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_req", mem_req, 0); chk("rst_addr", mem_addr, 0); chk("rst_result", result, 0);
    last_res = 32'h0;
    for (int i = 0; i < 18; i++) begin
      req = 1'b1; we = v[i].we; opt = v[i].opt; addr = v[i].addr; wdata = v[i].wdata;
      mem_ack = 1'b1; mem_rdata = v[i].rdata;
      @(negedge clk);
      req = 1'b0;
      if (v[i].err) begin
        chk($sformatf("v%0d_err", i), err, 1);
        chk($sformatf("v%0d_noreq", i), mem_req, 0);
        chk($sformatf("v%0d_nobusy", i), busy, 0);
        chk($sformatf("v%0d_nodone", i), done, 0);
      end else begin
        chk($sformatf("v%0d_req", i), mem_req, 1);
        chk($sformatf("v%0d_we", i), mem_we, v[i].we);
        chk($sformatf("v%0d_busy", i), busy, 1);
        chk($sformatf("v%0d_maddr", i), mem_addr, v[i].maddr);
        chk($sformatf("v%0d_strb", i), mem_wstrb, v[i].strb);
        if (v[i].we) chk($sformatf("v%0d_wdata", i), mem_wdata, v[i].mwdata);
        @(negedge clk);
        chk($sformatf("v%0d_done", i), done, 1);
        chk($sformatf("v%0d_noerr", i), err, 0);
        chk($sformatf("v%0d_busy0", i), busy, 0);
        chk($sformatf("v%0d_req0", i), mem_req, 0);
        if (!v[i].we) last_res = v[i].res;
        chk($sformatf("v%0d_result", i), result, last_res);
      end
      mem_ack = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", i), done | err, 0);
    end
    // timeout: no acknowledge at all
    req = 1'b1; we = 1'b0; opt = 3'b010; addr = 32'h300; mem_ack = 1'b0;
    @(negedge clk);
    req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("to_req_c%0d", c), mem_req, 1);
      chk($sformatf("to_noerr_c%0d", c), err, 0);
      @(negedge clk);
    end
    chk("to_req_drop", mem_req, 0);
    chk("to_err", err, 1);
    chk("to_nodone", done, 0);
    chk("to_busy0", busy, 0);
    chk("to_result_hold", result, last_res);
    @(negedge clk);
    chk("to_err_pulse", err, 0);
    // acknowledge on the same edge the counter would expire: ack wins
    req = 1'b1; opt = 3'b010; addr = 32'h304;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("edge_req_still", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("edge_done", done, 1);
    chk("edge_noerr", err, 0);
    chk("edge_result", result, 32'h5555AAAA);
    @(negedge clk);
    // reset in the middle of an access
    req = 1'b1; we = 1'b1; opt = 3'b111; addr = 32'h400; wdata = 32'h89ABCDEF;
    @(negedge clk);
    req = 1'b0;
    chk("rs_req_before", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs_req", mem_req, 0); chk("rs_we", mem_we, 0); chk("rs_busy", busy, 0);
    chk("rs_addr", mem_addr, 0); chk("rs_strb", mem_wstrb, 0); chk("rs_wdata", mem_wdata, 0);
    chk("rs_result", result, 0); chk("rs_done", done, 0); chk("rs_err", err, 0);
    // new load, with a second REQ arriving while busy
    req = 1'b1; we = 1'b0; opt = 3'b010; addr = 32'h500;
    @(negedge clk);
    chk("bz_busy", busy, 1);
    we = 1'b1; opt = 3'b111; addr = 32'h600; wdata = 32'h1;
    @(negedge clk);
    chk("bz_addr_hold", mem_addr, 32'h500);
    chk("bz_we_hold", mem_we, 0);
    req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h00000077;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (done) n_done++;
    end
    chk("bz_one_done", n_done, 1);
    chk("bz_result", result, 32'h00000077);
    chk("bz_idle_req", mem_req, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
